// File: rtl/bus_reader64.sv
// Read sequencer for the shared 64-bit result bus: enable, settle, capture, send as 32-bit beats.
// Optional BUS_READER64_ERR_EN adds an err flag for out-of-range source requests.
module bus_reader64 #(
  parameter int NSRC   = 4,
  parameter int SRCW   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SRCW-1:0] req_src,
  input  logic            req_lo_only,
  output logic [NSRC-1:0] src_oe,
  input  logic [63:0]     bus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_hi,
`ifdef BUS_READER64_ERR_EN
  output logic            out_last,
  output logic            err
`else
  output logic            out_last
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_LO,
    S_HI
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [63:0]     hold;
  logic            lo_only;
  logic            oor;
  logic            req_oor;
  logic [NSRC-1:0] req_oh;
  logic [63:0]     cap;
  logic            accept;
  logic            done;

  assign req_oor = 32'(req_src) >= 32'(NSRC);
  assign req_oh  = req_oor ? '0 : (NSRC'(1) << req_src);
  assign cap     = oor ? 64'h0 : bus;
  assign accept  = (state == S_IDLE) && req_ready && req_valid;
  assign done    = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      src_oe    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hi    <= 1'b0;
      out_last  <= 1'b0;
      hold      <= '0;
      cnt       <= '0;
      lo_only   <= 1'b0;
      oor       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            lo_only   <= req_lo_only;
            oor       <= req_oor;
            cnt       <= 4'(SETTLE);
            src_oe    <= req_oh;
            req_ready <= 1'b0;
            state     <= S_SETTLE;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd0) begin
            hold      <= cap;
            src_oe    <= '0;
            out_valid <= 1'b1;
            out_data  <= cap[31:0];
            out_hi    <= 1'b0;
            out_last  <= lo_only;
            state     <= S_LO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LO: begin
          if (!out_ready) begin
            out_data <= hold[31:0];
          end else if (lo_only) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            out_data <= hold[63:32];
            out_hi   <= 1'b1;
            out_last <= 1'b1;
            state    <= S_HI;
          end
        end
        S_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef BUS_READER64_ERR_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= req_oor;
    end else if (done) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_bus_reader64.sv
// Randomized bench for bus_reader64 against a transaction-timeline model.
// Second instance covers the zero-settle build.
module tb_bus_reader64;

  localparam int NSRC   = 3;
  localparam int SRCW   = 2;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [SRCW-1:0] req_src = '0;
  logic            req_lo_only = 1'b0;
  logic [NSRC-1:0] src_oe;
  logic [63:0]     bus = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_data;
  logic            out_hi;
  logic            out_last;
  logic            err;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic [1:0]  z_req_src = '0;
  logic        z_req_lo_only = 1'b0;
  logic [3:0]  z_src_oe;
  logic [63:0] z_bus = '0;
  logic        z_out_valid;
  logic        z_out_ready = 1'b1;
  logic [31:0] z_out_data;
  logic        z_out_hi;
  logic        z_out_last;
  logic        z_err;

  bus_reader64 #(.NSRC(NSRC), .SRCW(SRCW), .SETTLE(SETTLE)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_lo_only(req_lo_only),
    .src_oe(src_oe), .bus(bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hi(out_hi),
`ifdef BUS_READER64_ERR_EN
    .err(err),
`endif
    .out_last(out_last)
  );

  bus_reader64 #(.NSRC(4), .SRCW(2), .SETTLE(0)) dut_z (
    .clk(clk), .clr(clr),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_src(z_req_src), .req_lo_only(z_req_lo_only),
    .src_oe(z_src_oe), .bus(z_bus),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .out_hi(z_out_hi),
`ifdef BUS_READER64_ERR_EN
    .err(z_err),
`endif
    .out_last(z_out_last)
  );

`ifndef BUS_READER64_ERR_EN
  assign err   = 1'b0;
  assign z_err = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        hi;
    logic        last;
  } beat_t;

  beat_t q[$];
  bit    active = 1'b0;
  bit    m_oor = 1'b0;
  bit    m_lo = 1'b0;
  bit    in_rst = 1'b1;
  int    m_src = 0;
  int    cap_at = 0;
  int    ready_at = 0;

  task automatic check_outputs();
    logic [63:0] e_oe;
    bit e_ready;
    e_ready = !in_rst && !active && (cyc >= ready_at);
    e_oe = '0;
    if (active && cyc < cap_at && !m_oor) e_oe[m_src] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("src_oe", 64'(src_oe), e_oe);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_hi", 64'(out_hi), 64'(q[0].hi));
      chk("out_last", 64'(out_last), 64'(q[0].last));
    end
`ifdef BUS_READER64_ERR_EN
    chk("err", 64'(err), 64'(active && m_oor));
`endif
  endtask

  task automatic drive(input bit rv, input int src, input bit lo,
                       input logic [63:0] b, input bit ordy);
    beat_t bt;
    int c;
    req_valid   = rv;
    req_src     = SRCW'(src);
    req_lo_only = lo;
    bus         = b;
    out_ready   = ordy;
    c = cyc;
    if (in_rst) return;
    if (q.size() > 0 && ordy) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        active   = 1'b0;
        ready_at = c + 1;
      end
    end else if (active && c + 1 == cap_at) begin
      bt.d    = m_oor ? 32'h0 : b[31:0];
      bt.hi   = 1'b0;
      bt.last = m_lo;
      q.push_back(bt);
      if (!m_lo) begin
        bt.d    = m_oor ? 32'h0 : b[63:32];
        bt.hi   = 1'b1;
        bt.last = 1'b1;
        q.push_back(bt);
      end
    end else if (!active && c >= ready_at && rv) begin
      active = 1'b1;
      m_src  = src;
      m_lo   = lo;
      m_oor  = src >= NSRC;
      cap_at = c + 2 + SETTLE;
    end
  endtask

  task automatic step(input bit rv, input int src, input bit lo,
                      input logic [63:0] b, input bit ordy);
    @(negedge clk);
    check_outputs();
    drive(rv, src, lo, b, ordy);
  endtask

  task automatic idle(input int n, input logic [63:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, b, 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst_src_oe", 64'(src_oe), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    in_rst = 1'b1;
    active = 1'b0;
    q.delete();
    idle(n, 64'h0);
    clr = 1'b0;
    clr = 1'b1;
    in_rst = 1'b0;
    ready_at = cyc + 1;
  endtask

  localparam logic [63:0] BV = 64'hDEADBEEF_01234567;

  initial begin
    idle(3, 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_hi", 64'(out_hi), 64'h0);
    chk("rst_out_last", 64'(out_last), 64'h0);
    clr = 1'b1;
    in_rst = 1'b0;
    ready_at = cyc + 1;
    idle(2, 64'h0);

    step(1'b1, 2, 1'b0, BV, 1'b1);
    idle(6, BV);

    step(1'b1, 2, 1'b0, BV, 1'b1);
    step(1'b0, 2, 1'b0, BV, 1'b0);
    step(1'b0, 2, 1'b0, BV, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2, 1'b0, 64'h0, 1'b0);
    idle(4, 64'h0);

    step(1'b1, 0, 1'b1, 64'h00000000_FFFFFFFF, 1'b1);
    idle(5, 64'h00000000_FFFFFFFF);

    z_req_valid = 1'b1;
    z_req_src = 2'd3;
    z_req_lo_only = 1'b0;
    z_bus = 64'h1111_2222_3333_4444;
    z_out_ready = 1'b1;
    idle(1, 64'h0);
    chk("z_oe_e0", 64'(z_src_oe), 64'h8);
    chk("z_valid_e0", 64'(z_out_valid), 64'h0);
    chk("z_ready_e0", 64'(z_req_ready), 64'h0);
    z_req_valid = 1'b0;
    idle(1, 64'h0);
    z_bus = 64'h0;
    chk("z_oe_e1", 64'(z_src_oe), 64'h0);
    chk("z_valid_e1", 64'(z_out_valid), 64'h1);
    chk("z_lo", 64'(z_out_data), 64'h33334444);
    chk("z_lo_hi", 64'(z_out_hi), 64'h0);
    chk("z_lo_last", 64'(z_out_last), 64'h0);
    idle(1, 64'h0);
    chk("z_hi", 64'(z_out_data), 64'h11112222);
    chk("z_hi_hi", 64'(z_out_hi), 64'h1);
    chk("z_hi_last", 64'(z_out_last), 64'h1);
    idle(1, 64'h0);
    chk("z_valid_end", 64'(z_out_valid), 64'h0);
    chk("z_ready_end", 64'(z_req_ready), 64'h1);

    step(1'b1, 1, 1'b0, BV, 1'b1);
    step(1'b0, 1, 1'b0, BV, 1'b1);
    do_reset(2);
    chk("z_rst_ready", 64'(z_req_ready), 64'h0);
    step(1'b1, 1, 1'b0, 64'hCAFEF00D_12345678, 1'b1);
    step(1'b1, 1, 1'b0, 64'hCAFEF00D_12345678, 1'b1);
    idle(6, 64'hCAFEF00D_12345678);

    step(1'b1, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    idle(6, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0));
      if (i == 1500) do_reset(1);
    end
    idle(8, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
